// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, reset PC and the fetch FSM states.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_ISSUE = 2'd2;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JR, then J/JAL, then taken BNE, else sequential.
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       instr,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              jump,
    input  logic              jump_sel,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] next_pc,
    output logic              misalign_c
);

    logic [ADDR_W-1:0] br_off_s;

    assign br_off_s = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

    // Priority select; JR target low bits are forced to zero and reported
    always_comb begin
        next_pc    = pc_plus4;
        misalign_c = 1'b0;
        if (jump && jump_sel) begin
            next_pc    = {rs_data[ADDR_W-1:2], 2'b00};
            misalign_c = |rs_data[1:0];
        end else if (jump) begin
            next_pc    = {pc_plus4[ADDR_W-1:28], instr[25:0], 2'b00};
        end else if (branch && !alu_zero) begin
            next_pc    = pc_plus4 + br_off_s;
        end else begin
            next_pc    = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// holds the instruction register until the datapath reports completion.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              exec_done,
    input  logic              jump,
    input  logic              jump_sel,
    input  logic              branch,
    input  logic              alu_zero,
    input  logic [ADDR_W-1:0] rs_data,
    output logic              misalign
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              req_q, req_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              misalign_c_s;

    assign pc_plus4_s = pc_q + ADDR_W'(32'd4);

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc_plus4   (pc_plus4_s),
        .instr      (instr_q[25:0]),
        .rs_data    (rs_data),
        .jump       (jump),
        .jump_sel   (jump_sel),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .next_pc    (next_pc_s),
        .misalign_c (misalign_c_s)
    );

    // FSM and datapath next-state; control inputs only matter on the completing ISSUE cycle
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = req_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_d = ST_ISSUE;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    state_d    = ST_FETCH;
                    pc_d       = next_pc_s;
                    valid_d    = 1'b0;
                    req_d      = 1'b1;
                    misalign_d = misalign_c_s;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers; async reset drops the request immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign misalign    = misalign_q;

endmodule
